demux_4_collect: RTL

Registered 1-to-4 lane demultiplexer and frame collector, the receive-side counterpart of the team's registered 4:1 selector. Each accepted `din` sample is steered into one of four lane registers, picked either by an explicit `sel` or by an internal wrapping pointer. When all four lanes hold fresh data, the block snapshots them into a stable parallel word and pulses `frame_done`.

---
 rtl/demux_4_collect_if.sv | 24 ++
 rtl/demux_4_collect.sv | 86 ++++++++
 2 files changed

// File: rtl/demux_4_collect_if.sv
// Bus for demux_4_collect: sample/steering inputs, plus the live-lane and frame outputs.
interface demux_4_collect_if #(parameter int DW = 1);
  logic              mode;
  logic [1:0]        sel;
  logic [DW-1:0]     din;
  logic              din_valid;
  logic              clr;
  logic [4*DW-1:0]   q;
  logic [3:0]        q_vld;
  logic [1:0]        ptr;
  logic [4*DW-1:0]   frame;
  logic              frame_done;
  logic              err;

  modport master (
    output mode, sel, din, din_valid, clr,
    input  q, q_vld, ptr, frame, frame_done, err
  );

  modport slave (
    input  mode, sel, din, din_valid, clr,
    output q, q_vld, ptr, frame, frame_done, err
  );
endinterface

// File: rtl/demux_4_collect.sv
// Registered 1:4 lane demux and frame collector; 1-cycle write latency, no backpressure (clr drops a sample).
// Define DEMUX4_ERR_EN to build the sticky addressed-overwrite err flag; otherwise err is tied to 0.
module demux_4_collect #(
  parameter int DW = 1
) (
  input  logic clk,
  input  logic rstn,
  demux_4_collect_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t              state, state_nxt;
  logic [3:0][DW-1:0]  lanes, lanes_nxt, frame_r;
  logic [3:0]          vld, vld_set;
  logic [1:0]          ptr_r, lane;
  logic                accept, complete, err_r;

  assign accept   = bus.din_valid && !bus.clr;
  assign lane     = bus.mode ? ptr_r : bus.sel;
  assign vld_set  = vld | (4'b0001 << lane);
  // An overwrite leaves vld_set == vld, which is never all ones, so it cannot complete.
  assign complete = accept && (vld_set == 4'hF);

  always_comb begin
    lanes_nxt       = lanes;
    lanes_nxt[lane] = bus.din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = complete ? DONE : FILL;
        FILL:    if (complete) state_nxt = DONE;
        DONE:    state_nxt = accept ? (complete ? DONE : FILL) : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lanes   <= '0;
      frame_r <= '0;
      vld     <= '0;
      ptr_r   <= '0;
    end else begin
      if (accept) lanes <= lanes_nxt;
      if (bus.clr) begin
        vld   <= '0;
        ptr_r <= '0;
      end else if (complete) begin
        vld     <= '0;
        ptr_r   <= '0;
        frame_r <= lanes_nxt;
      end else if (accept) begin
        vld <= vld_set;
        if (bus.mode) ptr_r <= ptr_r + 2'd1;
      end
    end
  end

`ifdef DEMUX4_ERR_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                   err_r <= 1'b0;
    else if (bus.clr)                            err_r <= 1'b0;
    else if (accept && !bus.mode && vld[lane])   err_r <= 1'b1;
  end
`else
  assign err_r = 1'b0;
`endif

  assign bus.q          = lanes;
  assign bus.q_vld      = vld;
  assign bus.ptr        = ptr_r;
  assign bus.frame      = frame_r;
  assign bus.frame_done = (state == DONE);
  assign bus.err        = err_r;
endmodule
